// File: rtl/rfphoenix_mcalu_tagq.sv
// Result-tag scheduler for the multi-cycle FP ALU.
// A writeback-slot pipeline: slot k holds the op whose result lands k cycles
// from now. Issues are placed at slot L of their class and refused when an
// older op would arrive on the result bus in the same cycle.
module rfphoenix_mcalu_tagq #(
  parameter int TIDW   = 4,
  parameter int NCLS   = 4,
  parameter int MAXLAT = 16,
  parameter int LAT0   = 8,
  parameter int LAT1   = 8,
  parameter int LAT2   = 4,
  parameter int LAT3   = 1,
  localparam int CLSW  = $clog2(NCLS),
  localparam int CNTW  = $clog2(MAXLAT + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce,
  input  logic            issue_v,
  input  logic [TIDW-1:0] issue_tid,
  input  logic [CLSW-1:0] issue_cls,
  output logic            issue_rdy,
  input  logic            flush_v,
  input  logic [TIDW-1:0] flush_tid,
  output logic            done,
  output logic [TIDW-1:0] rido,
  output logic [CLSW-1:0] rcls,
  output logic [CNTW-1:0] inflight
);

  // Refuse to elaborate with a class latency the slot array cannot hold.
  if (LAT0 < 1 || LAT0 > MAXLAT) begin : g_bad_lat0
    $error("LAT0 outside 1..MAXLAT");
  end
  if (LAT1 < 1 || LAT1 > MAXLAT) begin : g_bad_lat1
    $error("LAT1 outside 1..MAXLAT");
  end
  if (LAT2 < 1 || LAT2 > MAXLAT) begin : g_bad_lat2
    $error("LAT2 outside 1..MAXLAT");
  end
  if (LAT3 < 1 || LAT3 > MAXLAT) begin : g_bad_lat3
    $error("LAT3 outside 1..MAXLAT");
  end

  typedef struct packed {
    logic            v;
    logic [TIDW-1:0] tid;
    logic [CLSW-1:0] cls;
  } slot_t;

  slot_t [MAXLAT:1] s_q, s_d;
  logic  [CNTW-1:0] inflight_q, inflight_d;
  logic  [CNTW-1:0] lat;
  logic             blocked;
  logic             accept;

  // Latency of the requesting class; unknown encodings fall back to class 0.
  always_comb begin
    lat = CNTW'(LAT0);
    case (issue_cls)
      CLSW'(1): lat = CNTW'(LAT1);
      CLSW'(2): lat = CNTW'(LAT2);
      CLSW'(3): lat = CNTW'(LAT3);
      default:  lat = CNTW'(LAT0);
    endcase
  end

  // An op landing at L collides with whatever sits one slot above L now,
  // since that one shifts into L this same edge. The top slot never collides.
  always_comb begin
    blocked = 1'b0;
    for (int k = 1; k < MAXLAT; k++) begin
      if (lat == CNTW'(k)) blocked = s_q[k+1].v;
    end
  end

  assign issue_rdy = ce & rst & ~blocked;
  assign accept    = issue_v & issue_rdy;

  // Shift, then flush the shifted copies, then place the accepted op so a
  // same-tid issue in the flush cycle survives (it is younger than the flush).
  always_comb begin
    s_d = s_q;
    if (ce) begin
      for (int k = 1; k < MAXLAT; k++) s_d[k] = s_q[k+1];
      s_d[MAXLAT] = '0;
      for (int k = 1; k <= MAXLAT; k++) begin
        if (flush_v && s_d[k].tid == flush_tid) s_d[k].v = 1'b0;
      end
      for (int k = 1; k <= MAXLAT; k++) begin
        if (accept && lat == CNTW'(k)) s_d[k] = '{v: 1'b1, tid: issue_tid, cls: issue_cls};
      end
    end
    inflight_d = '0;
    for (int k = 1; k <= MAXLAT; k++) inflight_d = inflight_d + CNTW'(s_d[k].v);
  end

  // Slot array and occupancy count; reset wins over ce.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s_q        <= '0;
      inflight_q <= '0;
    end else begin
      s_q        <= s_d;
      inflight_q <= inflight_d;
    end
  end

  // Result presentation from the bottom slot; zeroed when not valid.
  assign done     = ce & rst & s_q[1].v;
  assign rido     = done ? s_q[1].tid : '0;
  assign rcls     = done ? s_q[1].cls : '0;
  assign inflight = inflight_q;

endmodule

// File: tb/tb_rfphoenix_mcalu_tagq.sv
// Directed bench for rfphoenix_mcalu_tagq: a per-cycle vector table for
// reset, single latency, collision and streaming, then hand-written flush,
// ce-hold and mid-op reset sequences.
module tb_rfphoenix_mcalu_tagq;

  logic       clk = 1'b0;
  logic       rst, ce, issue_v, flush_v;
  logic [3:0] issue_tid, flush_tid;
  logic [1:0] issue_cls;
  logic       issue_rdy, done;
  logic [3:0] rido;
  logic [1:0] rcls;
  logic [4:0] inflight;

  always #5 clk = ~clk;

  rfphoenix_mcalu_tagq dut (
    .clk(clk), .rst(rst), .ce(ce),
    .issue_v(issue_v), .issue_tid(issue_tid), .issue_cls(issue_cls),
    .issue_rdy(issue_rdy),
    .flush_v(flush_v), .flush_tid(flush_tid),
    .done(done), .rido(rido), .rcls(rcls), .inflight(inflight)
  );

  typedef struct {
    logic       rst, ce, iv;
    logic [3:0] itid;
    logic [1:0] icls;
    logic       fv;
    logic [3:0] ftid;
    logic       edone;
    logic [3:0] erido;
    logic [1:0] ercls;
    logic       erdy;
    logic [4:0] einf;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic c, input logic iv, input logic [3:0] it,
                       input logic [1:0] ic, input logic fv, input logic [3:0] ft);
    rst = r; ce = c; issue_v = iv; issue_tid = it; issue_cls = ic;
    flush_v = fv; flush_tid = ft;
    #1;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic vec_t mk(logic r, logic c, logic iv, logic [3:0] it, logic [1:0] ic,
                              logic fv, logic [3:0] ft, logic ed, logic [3:0] er,
                              logic [1:0] ec, logic ey, logic [4:0] ei);
    vec_t v;
    v.rst = r; v.ce = c; v.iv = iv; v.itid = it; v.icls = ic; v.fv = fv; v.ftid = ft;
    v.edone = ed; v.erido = er; v.ercls = ec; v.erdy = ey; v.einf = ei;
    return v;
  endfunction

  task automatic idle(input int n, input logic [4:0] inf);
    for (int i = 0; i < n; i++) tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, inf));
  endtask

  // Idle ce=1 cycle with checks on done/rido/rcls/inflight.
  task automatic idle_chk(input string nm, input logic ed, input logic [3:0] er,
                          input logic [1:0] ec, input logic [4:0] ei);
    drive(1, 1, 0, 0, 0, 0, 0);
    chk({nm, ".done"}, done, ed);
    chk({nm, ".rido"}, rido, er);
    chk({nm, ".rcls"}, rcls, ec);
    chk({nm, ".inflight"}, inflight, ei);
    adv();
  endtask

  initial begin
    int fl_inf[14];
    // ---- vector table ----
    // reset held 3 checked cycles (one unchecked cycle precedes it)
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // single latency: issue tid 5 cls 0 at 10, done at 18
    idle(10, 0);
    tbl.push_back(mk(1, 1, 1, 5, 0, 0, 0, 0, 0, 0, 1, 0));
    idle(7, 1);
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 5, 0, 1, 1));
    idle(1, 0);
    // collision: cls0 at B, cls2 refused at B+4, accepted at B+5
    tbl.push_back(mk(1, 1, 1, 3, 0, 0, 0, 0, 0, 0, 1, 0));
    idle(3, 1);
    tbl.push_back(mk(1, 1, 1, 7, 2, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 1, 1, 7, 2, 0, 0, 0, 0, 0, 1, 1));
    idle(2, 2);
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 3, 0, 1, 2));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 7, 2, 1, 1));
    idle(1, 0);
    // streaming: 16 back-to-back cls3 issues
    for (int i = 0; i < 16; i++)
      tbl.push_back(mk(1, 1, 1, 4'(i), 3, 0, 0, (i > 0), (i > 0) ? 4'(i - 1) : 4'd0,
                       (i > 0) ? 2'd3 : 2'd0, 1, (i > 0) ? 5'd1 : 5'd0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1, 15, 3, 1, 1));
    idle(1, 0);

    drive(0, 1, 0, 0, 0, 0, 0);
    adv();
    cyc = 0;
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].ce, tbl[i].iv, tbl[i].itid, tbl[i].icls, tbl[i].fv, tbl[i].ftid);
      chk("tbl.done", done, tbl[i].edone);
      chk("tbl.rido", rido, tbl[i].erido);
      chk("tbl.rcls", rcls, tbl[i].ercls);
      chk("tbl.rdy", issue_rdy, tbl[i].erdy);
      chk("tbl.inflight", inflight, tbl[i].einf);
      adv();
    end

    // ---- flush: tids 1,2,1,2 then flush tid1 with a new tid1 issue ----
    cyc = 0;
    for (int c = 0; c < 4; c++) begin
      drive(1, 1, 1, (c % 2 == 0) ? 4'd1 : 4'd2, 0, 0, 0);
      chk("fl.rdy", issue_rdy, 1);
      adv();
    end
    drive(1, 1, 1, 1, 0, 1, 1);
    chk("fl.rdy4", issue_rdy, 1);
    chk("fl.inf4", inflight, 4);
    adv();
    fl_inf = '{0, 0, 0, 0, 0, 3, 3, 3, 3, 3, 2, 2, 1, 0};
    for (int c = 5; c < 14; c++) begin
      if (c == 9 || c == 11) idle_chk("fl", 1, 2, 0, 5'(fl_inf[c]));
      else if (c == 12)      idle_chk("fl", 1, 1, 0, 5'(fl_inf[c]));
      else                   idle_chk("fl", 0, 0, 0, 5'(fl_inf[c]));
    end

    // ---- ce hold: cls0 at 0, ce low 3..5 (flush of same tid ignored) ----
    cyc = 0;
    drive(1, 1, 1, 9, 0, 0, 0);
    adv();
    for (int c = 1; c < 3; c++) idle_chk("ce", 0, 0, 0, 1);
    for (int c = 3; c < 6; c++) begin
      drive(1, 0, 1, 4, 0, (c == 4), 9);
      chk("ce.rdy", issue_rdy, 0);
      chk("ce.done", done, 0);
      chk("ce.inflight", inflight, 1);
      adv();
    end
    for (int c = 6; c < 11; c++) idle_chk("ce", 0, 0, 0, 1);
    idle_chk("ce11", 1, 9, 0, 1);
    idle_chk("ce12", 0, 0, 0, 0);

    // ---- mid-op reset at 4 ----
    cyc = 0;
    drive(1, 1, 1, 9, 0, 0, 0);
    adv();
    for (int c = 1; c < 4; c++) idle_chk("rs", 0, 0, 0, 1);
    drive(0, 1, 1, 9, 0, 0, 0);
    chk("rs.rdy", issue_rdy, 0);
    chk("rs.done", done, 0);
    adv();
    for (int c = 5; c < 15; c++) idle_chk("rs", 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
